spiking_lif_layer: RTL and testbench

Parametrised layer of N_OUT leaky integrate-and-fire neurons, fully connected to N_IN spike inputs. It is the generalised successor of the fixed two-input XOR neuron network.
- Weights and per-neuron thresholds are programmed at run time over the addr/cmd/cmd_arg bus.
- Layers chain by connecting out_spk of one layer to in_spk of the next.
- A per-neuron saturating spike counter is readable for training and annealing loops.

---
 rtl/spiking_lif_layer.sv | 202 ++++++++++++++++++++
 tb/tb_spiking_lif_layer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spiking_lif_layer.sv
// Layer of N_OUT leaky integrate-and-fire neurons, fully connected to N_IN
// spike inputs. Weights and thresholds are written over the addr/cmd/cmd_arg
// bus. Each neuron keeps a saturating spike counter that can be read back
// through rd_addr/rd_cnt.
module spiking_lif_layer #(
    parameter int N_IN        = 2,
    parameter int N_OUT       = 2,
    parameter int INT_WIDTH   = 4,
    parameter int FLOAT_WIDTH = 2 * INT_WIDTH,
    parameter int V_WIDTH     = FLOAT_WIDTH + 2,
    parameter int LEAK_SHIFT  = 2,
    parameter int REFRACT     = 2,
    parameter int CNT_WIDTH   = 8,
    parameter int ADDR_WIDTH  = 3,
    parameter int CMD_WIDTH   = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_WIDTH-1:0]  addr,
    input  logic [CMD_WIDTH-1:0]   cmd,
    input  logic [FLOAT_WIDTH-1:0] cmd_arg,
    input  logic                   run,
    input  logic [N_IN-1:0]        in_spk,
    output logic [N_OUT-1:0]       out_spk,
    input  logic [ADDR_WIDTH-1:0]  rd_addr,
    output logic [CNT_WIDTH-1:0]   rd_cnt
);

    // The pre-saturation sum is wide enough for v minus its leak plus
    // every weight of the row at once.
    localparam int S_WIDTH = V_WIDTH + $clog2(N_IN) + 1;
    // The refractory counter must hold REFRACT. At least 1 bit is kept
    // so that REFRACT = 0 still builds.
    localparam int R_WIDTH = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
    localparam logic [CMD_WIDTH-1:0]          CMD_THR  = {CMD_WIDTH{1'b1}};
    localparam logic signed [FLOAT_WIDTH-1:0] THR_ONE  = FLOAT_WIDTH'(1'b1) << INT_WIDTH;
    localparam logic [CNT_WIDTH-1:0]          CNT_MAX  = {CNT_WIDTH{1'b1}};

    // Programmable parameters and neuron state
    logic [N_IN-1:0][FLOAT_WIDTH-1:0] w_r    [N_OUT];
    logic signed [FLOAT_WIDTH-1:0]    thr_r  [N_OUT];
    logic signed [V_WIDTH-1:0]        v_r    [N_OUT];
    logic [R_WIDTH-1:0]               refr_r [N_OUT];
    logic [CNT_WIDTH-1:0]             cnt_r  [N_OUT];
    logic [N_OUT-1:0]                 out_spk_r;
    logic [CNT_WIDTH-1:0]             rd_cnt_r;

    // Combinational step results and write decode
    logic signed [V_WIDTH-1:0]        s_sat_s [N_OUT];
    logic [N_OUT-1:0]                 fire_s;
    logic [N_OUT-1:0]                 wr_thr_s;
    logic [N_OUT-1:0][N_IN-1:0]       wr_w_s;
    logic [CNT_WIDTH-1:0]             rd_sel_s;

    // Leaky integration: v - (v >>> LEAK_SHIFT) + sum of weights of active inputs
    function automatic logic signed [S_WIDTH-1:0] step_sum(
        input logic signed [V_WIDTH-1:0]      v,
        input logic [N_IN-1:0][FLOAT_WIDTH-1:0] w,
        input logic [N_IN-1:0]                spk
    );
        logic signed [V_WIDTH-1:0]     leak;
        logic signed [FLOAT_WIDTH-1:0] wi;
        logic signed [S_WIDTH-1:0]     acc;
        leak = v >>> LEAK_SHIFT;
        acc  = S_WIDTH'(v) - S_WIDTH'(leak);
        for (int i = 0; i < N_IN; i++) begin
            wi = w[i];
            if (spk[i]) begin
                acc = acc + S_WIDTH'(wi);
            end else begin
                acc = acc;
            end
        end
        return acc;
    endfunction

    // Clamp the wide sum to the signed range of the membrane register
    function automatic logic signed [V_WIDTH-1:0] sat_v(input logic signed [S_WIDTH-1:0] x);
        logic signed [V_WIDTH-1:0] r;
        if (x[S_WIDTH-1:V_WIDTH-1] == {(S_WIDTH-V_WIDTH+1){x[S_WIDTH-1]}}) begin
            r = x[V_WIDTH-1:0];
        end else if (x[S_WIDTH-1]) begin
            r = {1'b1, {(V_WIDTH-1){1'b0}}};
        end else begin
            r = {1'b0, {(V_WIDTH-1){1'b1}}};
        end
        return r;
    endfunction

    // A non-positive threshold would fire with no input, so it is stored as 1
    function automatic logic signed [FLOAT_WIDTH-1:0] clamp_thr(input logic signed [FLOAT_WIDTH-1:0] x);
        logic signed [FLOAT_WIDTH-1:0] r;
        if (x[FLOAT_WIDTH-1] || (x == {FLOAT_WIDTH{1'b0}})) begin
            r = {{(FLOAT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r = x;
        end
        return r;
    endfunction

    // Decode the write bus. Out-of-range addresses and undefined commands match nothing.
    always_comb begin
        wr_thr_s = '0;
        wr_w_s   = '0;
        for (int j = 0; j < N_OUT; j++) begin
            wr_thr_s[j] = (addr == ADDR_WIDTH'(j)) && (cmd == CMD_THR);
            for (int i = 0; i < N_IN; i++) begin
                wr_w_s[j][i] = (addr == ADDR_WIDTH'(j)) && (cmd == CMD_WIDTH'(i + 1))
                               && (cmd != CMD_THR);
            end
        end
    end

    // Candidate membrane value and fire decision for each neuron, from the current registers
    always_comb begin
        fire_s = '0;
        for (int j = 0; j < N_OUT; j++) begin
            s_sat_s[j] = sat_v(step_sum(v_r[j], w_r[j], in_spk));
            fire_s[j]  = (s_sat_s[j] >= V_WIDTH'(thr_r[j]));
        end
    end

    // Counter read multiplexer. It yields zero when rd_addr is outside the layer.
    always_comb begin
        rd_sel_s = '0;
        for (int j = 0; j < N_OUT; j++) begin
            rd_sel_s = rd_sel_s | ((rd_addr == ADDR_WIDTH'(j)) ? cnt_r[j] : {CNT_WIDTH{1'b0}});
        end
    end

    // Weight and threshold registers. A step in the same cycle still sees the old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < N_OUT; j++) begin
                w_r[j]   <= '0;
                thr_r[j] <= THR_ONE;
            end
        end else begin
            for (int j = 0; j < N_OUT; j++) begin
                if (wr_thr_s[j]) begin
                    thr_r[j] <= clamp_thr(cmd_arg);
                end else begin
                    thr_r[j] <= thr_r[j];
                end
                for (int i = 0; i < N_IN; i++) begin
                    if (wr_w_s[j][i]) begin
                        w_r[j][i] <= cmd_arg;
                    end else begin
                        w_r[j][i] <= w_r[j][i];
                    end
                end
            end
        end
    end

    // Membrane, refractory, spike counter and output spike update for each step
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < N_OUT; j++) begin
                v_r[j]    <= '0;
                refr_r[j] <= '0;
                cnt_r[j]  <= '0;
            end
            out_spk_r <= '0;
        end else if (run) begin
            for (int j = 0; j < N_OUT; j++) begin
                if (refr_r[j] != '0) begin
                    refr_r[j]    <= refr_r[j] - R_WIDTH'(1'b1);
                    v_r[j]       <= '0;
                    out_spk_r[j] <= 1'b0;
                end else if (fire_s[j]) begin
                    refr_r[j]    <= R_WIDTH'(REFRACT);
                    v_r[j]       <= '0;
                    out_spk_r[j] <= 1'b1;
                    if (cnt_r[j] != CNT_MAX) begin
                        cnt_r[j] <= cnt_r[j] + CNT_WIDTH'(1'b1);
                    end else begin
                        cnt_r[j] <= cnt_r[j];
                    end
                end else begin
                    v_r[j]       <= s_sat_s[j];
                    out_spk_r[j] <= 1'b0;
                end
            end
        end else begin
            out_spk_r <= '0;
        end
    end

    // Registered counter read. It returns the value held before any increment in this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_r <= '0;
        end else begin
            rd_cnt_r <= rd_sel_s;
        end
    end

    assign out_spk = out_spk_r;
    assign rd_cnt  = rd_cnt_r;

endmodule

// File: tb/tb_spiking_lif_layer.sv
// Self-checking bench for spiking_lif_layer. An integer model of the layer is
// advanced at every clock edge. A compare process checks out_spk and rd_cnt
// against the model on every negative edge. Directed scenarios add literal
// expectations on the DUT and on the model.
module tb_spiking_lif_layer;

    localparam int N_IN       = 2;
    localparam int N_OUT      = 2;
    localparam int LEAK_SHIFT = 2;
    localparam int REFRACT    = 2;
    localparam int CNT_MAX    = 255;
    localparam int VMAX       = 511;
    localparam int VMIN       = -512;
    localparam int CMD_THR    = 7;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] addr;
    logic [2:0] cmd;
    logic [7:0] cmd_arg;
    logic       run;
    logic [1:0] in_spk;
    logic [1:0] out_spk;
    logic [2:0] rd_addr;
    logic [7:0] rd_cnt;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Behavioural model state
    int         mw   [N_OUT][N_IN];
    int         mthr [N_OUT];
    int         mv   [N_OUT];
    int         mrefr[N_OUT];
    int         mcnt [N_OUT];
    logic [1:0] exp_out;
    int         exp_rd;

    spiking_lif_layer dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .cmd     (cmd),
        .cmd_arg (cmd_arg),
        .run     (run),
        .in_spk  (in_spk),
        .out_spk (out_spk),
        .rd_addr (rd_addr),
        .rd_cnt  (rd_cnt)
    );

    always #5 clk = ~clk;

    // Advance the model by one edge, using the inputs held before that edge
    task automatic model_step();
        int s;
        int a;
        int c;
        int arg;
        int ra;
        if (rst) begin
            for (int j = 0; j < N_OUT; j++) begin
                for (int i = 0; i < N_IN; i++) mw[j][i] = 0;
                mthr[j] = 16; mv[j] = 0; mrefr[j] = 0; mcnt[j] = 0;
            end
            exp_out = 2'b00;
            exp_rd  = 0;
        end else begin
            ra = int'(rd_addr);
            exp_rd = (ra < N_OUT) ? mcnt[ra] : 0;
            for (int j = 0; j < N_OUT; j++) begin
                if (!run) begin
                    exp_out[j] = 1'b0;
                end else if (mrefr[j] > 0) begin
                    mrefr[j] = mrefr[j] - 1;
                    mv[j] = 0;
                    exp_out[j] = 1'b0;
                end else begin
                    s = mv[j] - (mv[j] >>> LEAK_SHIFT);
                    for (int i = 0; i < N_IN; i++) if (in_spk[i]) s = s + mw[j][i];
                    if (s > VMAX) s = VMAX;
                    if (s < VMIN) s = VMIN;
                    if (s >= mthr[j]) begin
                        exp_out[j] = 1'b1;
                        mv[j] = 0;
                        mrefr[j] = REFRACT;
                        if (mcnt[j] < CNT_MAX) mcnt[j] = mcnt[j] + 1;
                    end else begin
                        exp_out[j] = 1'b0;
                        mv[j] = s;
                    end
                end
            end
            a   = int'(addr);
            c   = int'(cmd);
            arg = $signed(cmd_arg);
            if (a < N_OUT) begin
                if (c == CMD_THR) mthr[a] = (arg <= 0) ? 1 : arg;
                else if (c >= 1 && c <= N_IN) mw[a][c-1] = arg;
            end
        end
    endtask

    // One clock: the model follows the edge, then inputs may change 1 time unit later
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic wr(input int a, input int c, input int arg);
        addr = 3'(a); cmd = 3'(c); cmd_arg = 8'(arg);
        tick();
        addr = 3'b111; cmd = 3'b000; cmd_arg = 8'h00;
    endtask

    task automatic step(input logic [1:0] spk);
        run = 1'b1; in_spk = spk;
        tick();
    endtask

    task automatic halt();
        run = 1'b0; in_spk = 2'b00;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; in_spk = 2'b00;
        tick();
        rst = 1'b0;
    endtask

    // Cycle-by-cycle comparison of DUT outputs against the model
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                checks++;
                if (out_spk !== exp_out) begin
                    errors++;
                    $display("FAIL out_spk t=%0t got %b expected %b", $time, out_spk, exp_out);
                end
                checks++;
                if (rd_cnt !== 8'(exp_rd)) begin
                    errors++;
                    $display("FAIL rd_cnt t=%0t got %0d expected %0d", $time, rd_cnt, exp_rd);
                end
            end
        end
    end

    // Directed scenarios
    initial begin
        int leak_seq[6];
        leak_seq = '{8, 6, 5, 4, 3, 3};
        rst = 1'b1; addr = 3'b111; cmd = 3'b000; cmd_arg = 8'h00;
        run = 1'b0; in_spk = 2'b00; rd_addr = 3'b000;
        tick();
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset_out", out_spk, 0);
        check("reset_rd", rd_cnt, 0);

        // Single fire, refractory with input held, refire on step 4
        wr(0, 1, 20);
        step(2'b01); check("fire_step1", out_spk, 1);
        step(2'b01); check("refr_step2", out_spk, 0);
        step(2'b01); check("refr_step3", out_spk, 0);
        step(2'b01); check("fire_step4", out_spk, 1);
        rd_addr = 3'b000;
        halt();      check("cnt0_two", rd_cnt, 2);

        // Reset while neuron 0 is refractory and neuron 1 holds v = 10
        wr(1, 1, 10);
        step(2'b01); check("pre_reset_out", out_spk, 0);
        check("model_v1_pre_reset", mv[1], 10);
        rst = 1'b1;
        tick();
        rst = 1'b0; run = 1'b0; in_spk = 2'b00;
        check("mid_reset_out", out_spk, 0);
        check("mid_reset_rd", rd_cnt, 0);
        wr(0, 1, 20);
        wr(1, 1, 10);
        step(2'b01); check("post_reset_fire", out_spk, 1);
        halt();

        // Integration of two pulses to a fire
        do_reset();
        wr(0, 1, 10);
        step(2'b01); check("model_int_v", mv[0], 10);
        check("int_no_fire", out_spk, 0);
        step(2'b01); check("int_fire", out_spk, 1);
        halt();

        // Single pulse decays without firing, then two probes reach threshold
        do_reset();
        wr(0, 1, 10);
        step(2'b01); check("model_leak_v0", mv[0], 10);
        for (int k = 0; k < 6; k++) begin
            step(2'b00);
            check("model_leak_v", mv[0], leak_seq[k]);
        end
        step(2'b01); check("model_probe_v", mv[0], 13);
        check("probe_no_fire", out_spk, 0);
        step(2'b01); check("probe_fire", out_spk, 1);
        halt();

        // Negative saturation, then recovery with a large positive weight
        do_reset();
        wr(0, 1, -128);
        step(2'b01); check("model_sat_v1", mv[0], -128);
        step(2'b01); check("model_sat_v2", mv[0], -224);
        step(2'b01); check("model_sat_v3", mv[0], -296);
        for (int k = 0; k < 5; k++) step(2'b01);
        halt();
        wr(0, 2, -128);
        for (int k = 0; k < 5; k++) step(2'b11);
        check("model_sat_clamp", mv[0], -512);
        halt();
        wr(0, 2, 0);
        wr(0, 1, 127);
        step(2'b01); check("recover1", out_spk, 0);
        check("model_recover_v1", mv[0], -257);
        step(2'b01); check("recover2", out_spk, 0);
        check("model_recover_v2", mv[0], -65);
        step(2'b01); check("recover_fire", out_spk, 1);
        halt();

        // XOR-style pair. 8 + 8 reaches the threshold exactly.
        do_reset();
        wr(0, 1, 8); wr(0, 2, 8); wr(1, 1, 18); wr(1, 2, 18);
        step(2'b01); check("xor_01", out_spk, 2);
        halt();
        do_reset();
        wr(0, 1, 8); wr(0, 2, 8); wr(1, 1, 18); wr(1, 2, 18);
        step(2'b11); check("xor_11", out_spk, 3);
        halt();

        // Threshold clamping, ignored commands and out-of-range addresses
        do_reset();
        wr(0, CMD_THR, 0);
        step(2'b00); check("thr_zero_stored_one", out_spk, 0);
        halt();
        wr(0, CMD_THR, -5);
        step(2'b00); check("thr_neg_stored_one", out_spk, 0);
        halt();
        wr(0, 5, 100);
        wr(2, CMD_THR, 100);
        wr(4, CMD_THR, 100);
        wr(0, 1, 1);
        step(2'b01); check("thr_one_fire", out_spk, 1);
        halt();

        // Counter saturation with reads racing increments
        do_reset();
        wr(1, 1, 20);
        rd_addr = 3'b001;
        for (int k = 0; k < 900; k++) step(2'b01);
        check("model_cnt_sat", mcnt[1], 255);
        halt();      check("cnt_sat", rd_cnt, 255);
        rd_addr = 3'b101;
        halt();      check("rd_out_of_range", rd_cnt, 0);
        rd_addr = 3'b000;

        // Weight write in the same cycle as a step uses the old weight
        do_reset();
        wr(1, 1, 20);
        addr = 3'b001; cmd = 3'b001; cmd_arg = 8'd5;
        step(2'b01);
        addr = 3'b111; cmd = 3'b000; cmd_arg = 8'h00;
        check("race_old_weight", out_spk, 2);
        step(2'b01);
        step(2'b01);
        step(2'b01); check("race_new_weight", out_spk, 0);
        check("model_race_v", mv[1], 5);
        for (int k = 0; k < 4; k++) step(2'b01);
        halt();

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
